// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage feeding a 2-entry {pc, inst} queue to decode.
// Word-addressed PC, redirect with flush, stops on the all-zero halt word.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] InstAdd,
  input  logic [31:0] MemInstOut,
  input  logic        RedirectEn,
  input  logic [31:0] RedirectPC,
  output logic        InstValid,
  output logic [31:0] InstOut,
  output logic [31:0] InstPC,
  input  logic        InstReady,
  output logic        Halted
);

  logic [31:0] r_pc;
  logic        r_stop;
  logic [1:0]  r_count;
  logic [31:0] r_q_pc   [0:1];
  logic [31:0] r_q_inst [0:1];

  logic        w_deq;
  logic        w_fetch;
  logic        w_halt_word;
  logic [1:0]  w_tail;

  assign w_deq       = (r_count != 2'd0) && InstReady;
  assign w_fetch     = !r_stop && !RedirectEn &&
                       ((r_count != 2'd2) || w_deq);
  assign w_halt_word = (MemInstOut == 32'h0);
  // Slot the new entry lands in, after any dequeue this cycle
  assign w_tail      = r_count - {1'b0, w_deq};

  // PC advance and stop flag; a halt word freezes the PC on its own address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_stop <= 1'b0;
    end else if (RedirectEn) begin
      r_pc   <= RedirectPC;
      r_stop <= 1'b0;
    end else if (w_fetch) begin
      if (w_halt_word) begin
        r_stop <= 1'b1;
      end else begin
        r_pc <= r_pc + 32'd1;
      end
    end
  end

  // Occupancy: redirect flushes, otherwise -deq +fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else if (RedirectEn) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_tail + {1'b0, w_fetch};
    end
  end

  // Queue storage: head lives in slot 0, slot 1 shifts down on dequeue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_pc[0]   <= 32'h0;
      r_q_pc[1]   <= 32'h0;
      r_q_inst[0] <= 32'h0;
      r_q_inst[1] <= 32'h0;
    end else if (!RedirectEn) begin
      if (w_deq) begin
        r_q_pc[0]   <= r_q_pc[1];
        r_q_inst[0] <= r_q_inst[1];
      end
      if (w_fetch) begin
        if (w_tail == 2'd0) begin
          r_q_pc[0]   <= r_pc;
          r_q_inst[0] <= MemInstOut;
        end else begin
          r_q_pc[1]   <= r_pc;
          r_q_inst[1] <= MemInstOut;
        end
      end
    end
  end

  assign InstAdd   = r_pc;
  assign InstValid = (r_count != 2'd0);
  assign InstOut   = InstValid ? r_q_inst[0] : 32'h0;
  assign InstPC    = InstValid ? r_q_pc[0] : 32'h0;
  assign Halted    = r_stop && (r_count == 2'd0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch stage.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstAdd;
  logic [31:0] MemInstOut;
  logic        RedirectEn = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        InstValid;
  logic [31:0] InstOut;
  logic [31:0] InstPC;
  logic        InstReady = 1'b0;
  logic        Halted;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];

  logic [31:0] m_pc;
  bit          m_stop;
  logic [31:0] m_qpc [$];
  logic [31:0] m_qinst [$];

  always #5 clk = ~clk;

  assign MemInstOut = mem[InstAdd[5:0]];

  inst_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .InstAdd    (InstAdd),
    .MemInstOut (MemInstOut),
    .RedirectEn (RedirectEn),
    .RedirectPC (RedirectPC),
    .InstValid  (InstValid),
    .InstOut    (InstOut),
    .InstPC     (InstPC),
    .InstReady  (InstReady),
    .Halted     (Halted)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return mem[a[5:0]];
  endfunction

  function automatic void m_reset();
    m_pc   = 32'h0;
    m_stop = 0;
    m_qpc.delete();
    m_qinst.delete();
  endfunction

  // One clock edge of the fetch stage, straight from its rules
  function automatic void m_step();
    bit deq;
    bit fetch;
    logic [31:0] w;
    deq   = (m_qpc.size() > 0) && InstReady;
    fetch = !m_stop && !RedirectEn && ((m_qpc.size() < 2) || deq);
    if (RedirectEn) begin
      m_qpc.delete();
      m_qinst.delete();
      m_pc   = RedirectPC;
      m_stop = 0;
    end else begin
      if (deq) begin
        void'(m_qpc.pop_front());
        void'(m_qinst.pop_front());
      end
      if (fetch) begin
        w = memf(m_pc);
        m_qpc.push_back(m_pc);
        m_qinst.push_back(w);
        if (w == 32'h0) m_stop = 1;
        else m_pc = m_pc + 32'd1;
      end
    end
  endfunction

  function automatic logic [97:0] exp_vec();
    bit v;
    v = m_qpc.size() > 0;
    return {v, v ? m_qinst[0] : 32'h0, v ? m_qpc[0] : 32'h0,
            m_pc, m_stop && (m_qpc.size() == 0)};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {InstValid, InstOut, InstPC, InstAdd, Halted};
  endfunction

  // Called at a negedge: apply inputs, settle
  task automatic drive(input bit rdy, input bit re, input logic [31:0] rpc);
    InstReady  = rdy;
    RedirectEn = re;
    RedirectPC = rpc;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    InstReady = 1'b0;
    RedirectEn = 1'b0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    m_reset();
    drive(1, 0, 0);
    vectors++;
    if (dut_vec() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected all zero", dut_vec());
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (InstValid !== 1'b0 || InstAdd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b addr=%h expected 0/0",
               InstValid, InstAdd);
    end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [4];
    exp_i = '{32'h77FF0008, 32'h77FF0001, 32'h77FF0001, 32'h77FF0005};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      vectors++;
      if ({InstValid, InstPC, InstOut} !== {1'b1, 32'(i), exp_i[i]}) begin
        miscompares++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 i, InstValid, InstPC, InstOut, i, exp_i[i]);
      end
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stream_model[%0d]: got %h expected %h",
                 i, dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h expected %h",
                 i, dut_vec(), exp_vec());
      end
      advance();
    end
    drive(0, 0, 0);
    vectors++;
    if ({InstAdd, InstValid, InstPC, InstOut} !==
        {32'd2, 1'b1, 32'd0, 32'h77FF0008}) begin
      miscompares++;
      $display("FAIL bp_full: got addr=%h v=%b pc=%h inst=%h expected addr=2 pc=0 inst=77ff0008",
               InstAdd, InstValid, InstPC, InstOut);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      vectors++;
      if ({InstValid, InstPC} !== {1'b1, 32'(i)} ||
          dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: got %h expected %h pc=%0d",
                 i, dut_vec(), exp_vec(), i);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    int n;
    reset_dut();
    n = 0;
    while (!(m_qpc.size() > 0 && m_qpc[0] == 32'd4) && n < 20) begin
      drive(1, 0, 0);
      advance();
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL redir_reach: head pc 4 not reached, got pc=%h", InstPC);
    end
    drive(0, 0, 0);
    advance();
    drive(1, 1, 32'd9);
    vectors++;
    if ({InstValid, InstPC} !== {1'b1, 32'd4} || m_qpc.size() != 2) begin
      miscompares++;
      $display("FAIL redir_pre: got v=%b pc=%h expected pc=4 with 2 queued",
               InstValid, InstPC);
    end
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstAdd} !== {1'b0, 32'd9}) begin
      miscompares++;
      $display("FAIL redir_bubble: got v=%b addr=%h expected v=0 addr=9",
               InstValid, InstAdd);
    end
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstPC, InstOut} !== {1'b1, 32'd9, 32'hC31F0001}) begin
      miscompares++;
      $display("FAIL redir_t0: got pc=%h inst=%h expected 9/c31f0001",
               InstPC, InstOut);
    end
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstPC, InstOut} !== {1'b1, 32'd10, 32'hC35F0001}) begin
      miscompares++;
      $display("FAIL redir_t1: got pc=%h inst=%h expected a/c35f0001",
               InstPC, InstOut);
    end
    advance();
  endtask

  task automatic test_halt();
    int hits;
    hits = 0;
    drive(1, 1, 32'd12);
    advance();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0);
      if (InstValid && InstPC == 32'd15 && InstOut == 32'h0) hits++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_model[%0d]: got %h expected %h",
                 i, dut_vec(), exp_vec());
      end
      advance();
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("FAIL halt_once: got %0d deliveries expected 1", hits);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      vectors++;
      if ({Halted, InstValid, InstAdd} !== {1'b1, 1'b0, 32'd15}) begin
        miscompares++;
        $display("FAIL halt_hold[%0d]: got h=%b v=%b addr=%h expected 1/0/f",
                 i, Halted, InstValid, InstAdd);
      end
      advance();
    end
  endtask

  task automatic test_redirect_from_halt();
    drive(1, 1, 32'd0);
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({Halted, InstValid, InstAdd} !== {1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL unhalt: got h=%b v=%b addr=%h expected 0/0/0",
               Halted, InstValid, InstAdd);
    end
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstPC, InstOut} !== {1'b1, 32'd0, 32'h77FF0008}) begin
      miscompares++;
      $display("FAIL unhalt_head: got pc=%h inst=%h expected 0/77ff0008",
               InstPC, InstOut);
    end
    advance();
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFF);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(i > 1, 0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h expected %h",
                 i, dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    drive(0, 0, 0);
    advance();
    drive(0, 0, 0);
    advance();
    drive(0, 0, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || m_qpc.size() != 2) begin
      miscompares++;
      $display("FAIL mid_pre: got %h expected %h", dut_vec(), exp_vec());
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_async: got %h expected all zero", dut_vec());
    end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstAdd} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_release: got v=%b addr=%h expected 0/0",
               InstValid, InstAdd);
    end
    advance();
    drive(1, 0, 0);
    vectors++;
    if ({InstValid, InstPC, InstOut} !== {1'b1, 32'd0, 32'h77FF0008}) begin
      miscompares++;
      $display("FAIL mid_refetch: got pc=%h inst=%h expected 0/77ff0008",
               InstPC, InstOut);
    end
    advance();
  endtask

  task automatic test_random();
    bit          rdy;
    bit          re;
    logic [31:0] rpc;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom % 4) != 0;
      re  = ($urandom % 16) == 0;
      case ($urandom % 8)
        0:       rpc = 32'd15;
        1:       rpc = 32'hFFFF_FFFE;
        default: rpc = $urandom % 64;
      endcase
      drive(rdy, re, rpc);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h",
                 i, dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0]  = 32'h77FF0008;
    mem[1]  = 32'h77FF0001;
    mem[2]  = 32'h77FF0001;
    mem[3]  = 32'h77FF0005;
    mem[9]  = 32'hC31F0001;
    mem[10] = 32'hC35F0001;
    mem[15] = 32'h0000_0000;
    mem[40] = 32'h0000_0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_from_halt();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage sitting directly upstream of the unified instruction/data memory: drives the memory's word-indexed instruction address, captures the combinationally returned instruction word, and buffers it in a 2-entry queue toward decode. It supports pipeline backpressure via valid/ready, branch/jump redirect with queue flush, and stops fetching on the all-zero halt word.

## Interface
- RESET_PC, 32'h0, word address fetched first after reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- InstAdd  output  32  instruction word address to memory; always equals PC register
- MemInstOut  input  32  instruction word from memory, valid combinationally in the same cycle as InstAdd
- RedirectEn  input  1  redirect request from execute (branch/jump taken)
- RedirectPC  input  32  redirect target word address
- InstValid  output  1  queue head valid
- InstOut  output  32  queue head instruction; 0 when InstValid=0
- InstPC  output  32  word address of queue head; 0 when InstValid=0
- InstReady  input  1  decode accepts head this cycle
- Halted  output  1  halt word fetched and queue fully drained

## Operation
- State: PC (32), queue of 2 entries {pc, inst}, count (0..2), stop flag.
- Dequeue: deq = InstValid && InstReady; removes head at clock edge.
- Fetch condition: fetch = !stop && !RedirectEn && (count<2 || deq). On fetch, enqueue {PC, MemInstOut} at tail; PC <= PC+1.
- Addressing is word-granular: increment by 1, not 4. PC wraps 32'hFFFFFFFF -> 32'h0 silently.
- Halt: if fetched MemInstOut == 32'h0, it is enqueued normally, stop <= 1, PC is not incremented (holds halt address). No further fetches until redirect or reset.
- Halted = stop && count==0 (combinational from registers).
- Redirect (highest priority): at edge, queue flushed (count <= 0), PC <= RedirectPC, stop <= 0, no enqueue that cycle. A deq occurring in the redirect cycle counts as accepted by decode; its entry is flushed anyway.
- Simultaneous enqueue+dequeue with count==2: head leaves, new entry enters; count stays 2.
- Simultaneous enqueue+dequeue with count==1: count stays 1, new entry becomes head.
- InstValid = count!=0. Head outputs come directly from queue registers (no combinational path from MemInstOut to InstOut).

## Timing
- Reset (async assert): PC=RESET_PC, count=0, stop=0; InstValid=0, InstOut=0, InstPC=0, Halted=0; InstAdd=RESET_PC immediately.
- Fetch-to-valid latency: 1 cycle (fetched in cycle N, visible at head in cycle N+1 if queue was empty).
- Throughput: 1 instruction/cycle with InstReady held high.
- Backpressure: with InstReady=0, queue fills to 2 after 2 fetch cycles; PC then holds, InstAdd stable.
- Redirect bubble: RedirectEn sampled at edge E; target fetched in cycle after E; InstValid for target at edge E+1. Exactly one cycle with InstValid=0 after redirect.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight queue contents discarded.
- Redirect while Halted or stop set: fetching resumes from RedirectPC next cycle.

## Test plan
- Reset RESET_PC=0, memory mem[0..3]=77FF0008,77FF0001,77FF0001,77FF0005, InstReady=1 -> InstValid rises one cycle after reset release; head sequence (InstPC,InstOut)=(0,77FF0008),(1,77FF0001),(2,77FF0001),(3,77FF0005) on consecutive cycles.
- Hold InstReady=0 for 5 cycles from reset -> count reaches 2, InstAdd holds at 2, head stays (0,77FF0008); release InstReady -> heads 0,1,2 on consecutive cycles, no duplicates or gaps.
- Redirect with RedirectPC=9 while queue holds PCs 4,5 -> queue flushed, one InstValid=0 cycle, next head (9,C31F0001) then (10,C35F0001).
- Fetch mem[15]=00000000 with InstReady=1 -> head (15,00000000) delivered once, InstAdd holds at 15, Halted=1 the cycle after it is dequeued; stays 1 for 10 cycles.
- While Halted, RedirectEn with RedirectPC=0 -> Halted=0 next cycle, head (0,77FF0008) following cycle.
- Assert rst mid-stream with 2 entries queued -> InstValid, InstOut, InstPC, Halted go 0 immediately, InstAdd=RESET_PC; refetch starts from RESET_PC after release.
